// File: rtl/demux.sv
// 1-to-8 demultiplexer: routes e1 to the output selected by {sel0,sel1,sel2}.
// OUT_REG selects a registered (1-cycle, async-cleared) or purely combinational output path.
module demux #(
  parameter int OUT_REG = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic s4,
  output logic s5,
  output logic s6,
  output logic s7,
  input  logic e1,
  input  logic sel0,
  input  logic sel1,
  input  logic sel2
);

  logic [2:0] idx_p0;
  logic [7:0] dec_p0;
  logic [7:0] s_out;

  // Shifting a single bit guarantees the result is one-hot or all-zero.
  function automatic logic [7:0] decode(input logic en, input logic [2:0] idx);
    logic [7:0] one;
    one    = {7'b0, en};
    decode = one << idx;
  endfunction

  // Stage p0: combinational decode of the current inputs
  assign idx_p0 = {sel0, sel1, sel2};
  assign dec_p0 = decode(e1, idx_p0);

  generate
    if (OUT_REG != 0) begin : g_reg
      logic [7:0] dec_p1;

      // Stage p1: output register, cleared immediately when reset asserts
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dec_p1 <= '0;
        end else begin
          dec_p1 <= dec_p0;
        end
      end

      assign s_out = dec_p1;
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign s_out          = dec_p0;
    end
  endgenerate

  assign {s7, s6, s5, s4, s3, s2, s1, s0} = s_out;

endmodule

// File: tb/tb_demux.sv
// Directed and random checks of demux in both registered and combinational builds.
// Inputs change 1 time unit after rising edges; outputs are sampled mid-cycle.
module tb_demux;

  logic clk;
  logic rst_n;
  logic e1, sel0, sel1, sel2;
  logic r0, r1, r2, r3, r4, r5, r6, r7;
  logic c0, c1, c2, c3, c4, c5, c6, c7;
  logic [7:0] rv, cv;

  int tests = 0;
  int fails = 0;

  demux #(.OUT_REG(1)) u_reg (
    .clk(clk), .rst_n(rst_n),
    .s0(r0), .s1(r1), .s2(r2), .s3(r3), .s4(r4), .s5(r5), .s6(r6), .s7(r7),
    .e1(e1), .sel0(sel0), .sel1(sel1), .sel2(sel2)
  );

  demux #(.OUT_REG(0)) u_comb (
    .clk(clk), .rst_n(rst_n),
    .s0(c0), .s1(c1), .s2(c2), .s3(c3), .s4(c4), .s5(c5), .s6(c6), .s7(c7),
    .e1(e1), .sel0(sel0), .sel1(sel1), .sel2(sel2)
  );

  assign rv = {r7, r6, r5, r4, r3, r2, r1, r0};
  assign cv = {c7, c6, c5, c4, c3, c2, c1, c0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v);
    {e1, sel0, sel1, sel2} = v;
  endtask

  // Step to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model(input logic [3:0] v);
    logic [7:0] r;
    r = 8'h00;
    if (v[3]) r[v[2:0]] = 1'b1;
    return r;
  endfunction

  initial begin
    logic [3:0] v;
    logic       prev_e1;

    // Reset state: registered outputs forced low, combinational build unaffected
    rst_n = 1'b0;
    drive(4'b1011);
    #2;
    check("reset_reg", rv, 8'h00);
    check("reset_comb", cv, 8'h08);
    tick();
    check("reset_hold_edge", rv, 8'h00);
    #1 rst_n = 1'b1;
    #1;
    check("release_before_edge", rv, 8'h00);
    tick();
    check("release_first_edge", rv, 8'h08);

    // Exhaustive sweep with 1-cycle-delayed expectation
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      drive(v);
      #1;
      check("sweep_comb", cv, model(v));
      tick();
      check("sweep_reg", rv, model(v));
    end

    // Select decode
    drive(4'b1101);
    tick();
    check("sel_101", rv, 8'h20);
    drive(4'b1010);
    tick();
    check("sel_010", rv, 8'h04);

    // Enable drop
    drive(4'b1111);
    tick();
    check("en_s7", rv, 8'h80);
    drive(4'b0111);
    tick();
    check("en_drop", rv, 8'h00);

    // Async reset mid-cycle with s3 high
    drive(4'b1011);
    tick();
    check("pre_reset_s3", rv, 8'h08);
    #1 rst_n = 1'b0;
    #1;
    check("async_clear", rv, 8'h00);
    drive(4'b1110);
    #1;
    check("reset_ignores_inputs", rv, 8'h00);
    rst_n = 1'b1;
    #1;
    check("released_no_edge", rv, 8'h00);
    tick();
    check("post_release_s6", rv, 8'h40);

    // Latency: mid-cycle change held off on registered build, immediate on comb build
    #2 drive(4'b1001);
    #1;
    check("latency_reg_hold", rv, 8'h40);
    check("latency_comb_now", cv, 8'h02);
    tick();
    check("latency_reg_edge", rv, 8'h02);

    // Random sweep with one-hot invariant
    prev_e1 = e1;
    for (int i = 0; i < 1000; i++) begin
      v = 4'($urandom_range(0, 15));
      drive(v);
      prev_e1 = v[3];
      tick();
      check_int("rand_onehot", ($countones(rv) <= 1) ? 1 : 0, 1);
      check_int("rand_pop_e1", $countones(rv), int'(prev_e1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
